// File: rtl/seek_e_arb_pkg.sv
// Shared constants and the e = c[14:13] + c[12:0] reduction used by seek_e_arb.
// Latency: none (combinational helper function only).
// Backpressure: not applicable.
`ifndef Datawidth
`define Datawidth 16
`endif

package seek_e_arb_pkg;

    localparam int DATAWIDTH = `Datawidth;

    // c[RED_HI:RED_MID] is the high fold, c[RED_MID-1:0] the low part.
    localparam int RED_HI  = 14;
    localparam int RED_MID = 13;

    // Result width: 13-bit low part plus a 2-bit fold never exceeds 8194, fits in 14 bits.
    localparam int E_W = RED_MID + 1;

    function automatic logic [E_W-1:0] reduce_e(input logic [RED_HI:0] c);
        return {{(E_W-2){1'b0}}, c[RED_HI:RED_MID]} + {1'b0, c[RED_MID-1:0]};
    endfunction

endpackage

// File: rtl/seek_e_arb_rr.sv
// Round-robin picker: first valid requester at or above rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: enable=0 forces an all-zero grant.
module seek_e_arb_rr
    import seek_e_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int j;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (enable && !grant_any && req_valid[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDW'(j);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seek_e_arb.sv
// Shares one e = c[14:13] + c[12:0] reduction stage between NREQ round-robin requesters.
// Latency: accept in cycle N gives rsp_valid in cycle N+2; one result per cycle.
// Backpressure: rsp_ready=0 stalls stage 2, then stage 1, then grants; optional stats via SEEK_E_ARB_STATS_EN.
module seek_e_arb
    import seek_e_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DATAWIDTH,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [IDW-1:0]     rsp_id,
    input  logic               rsp_ready,
    output logic               busy
`ifdef SEEK_E_ARB_STATS_EN
    ,
    output logic [31:0]        stat_cnt,
    output logic [31:0]        stat_stall
`endif
);

    logic              s1_vld;
    logic [RED_HI:0]   s1_c;
    logic [IDW-1:0]    s1_id;
    logic              s2_vld;
    logic [E_W-1:0]    s2_e;
    logic [IDW-1:0]    s2_id;
    logic [IDW-1:0]    rr_ptr;
    logic              adv1;
    logic              adv2;
    logic              pick_en;
    logic [IDW-1:0]    grant_idx;
    logic              grant_any;
    logic [DW-1:0]     sel_c;
    logic              unused_hi;

    assign adv2    = !s2_vld || rsp_ready;
    assign adv1    = !s1_vld || adv2;
    // No grants while reset is held.
    assign pick_en = adv1 && !rst;

    seek_e_arb_rr #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (pick_en),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Select the granted requester's c; grant is one-hot so OR-ing is safe.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) sel_c = sel_c | req_data[i*DW +: DW];
        end
    end

    // Bits above c[14] never contribute to e.
    assign unused_hi = ^sel_c[DW-1:RED_HI+1];

    // Advance the round-robin pointer past the requester just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    // Stage 1: capture the granted c and its owner tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_c   <= '0;
            s1_id  <= '0;
        end else if (adv1) begin
            s1_vld <= grant_any;
            if (grant_any) begin
                s1_c  <= sel_c[RED_HI:0];
                s1_id <= grant_idx;
            end
        end
    end

    // Stage 2: reduce and hold the result until downstream takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_e   <= '0;
            s2_id  <= '0;
        end else if (adv2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_e  <= reduce_e(s1_c);
                s2_id <= s1_id;
            end
        end
    end

    assign rsp_valid = s2_vld;
    assign rsp_data  = {{(DW-E_W){1'b0}}, s2_e};
    assign rsp_id    = s2_id;
    assign busy      = s1_vld || s2_vld;

`ifdef SEEK_E_ARB_STATS_EN
    // Accepted-request counter (wraps) and output-stall counter (saturates).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt   <= '0;
            stat_stall <= '0;
        end else begin
            if (grant_any) stat_cnt <= stat_cnt + 32'd1;
            if (s2_vld && !rsp_ready && (stat_stall != '1)) stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seek_e_arb.sv
// Directed bench for seek_e_arb: reset, single requests, round-robin order, skip, backpressure.
// Latency: checks the two-cycle accept-to-response timing.
// Backpressure: holds rsp_ready low with a full pipe and checks stability and ordering.
module tb_seek_e_arb;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_ready;
    logic               busy;
`ifdef SEEK_E_ARB_STATS_EN
    logic [31:0]        stat_cnt;
    logic [31:0]        stat_stall;
`endif

    int n_cmp;
    int n_err;

    logic [DW-1:0] exp_e [4];
    logic [IDW-1:0] skip_id [3];

    seek_e_arb #(
        .NREQ (NREQ),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
`ifdef SEEK_E_ARB_STATS_EN
        ,
        .stat_cnt  (stat_cnt),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Move to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                             input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        req_data = {c3, c2, c1, c0};
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_data  = '0;
        rsp_ready = 1'b1;
        exp_e[0] = 16'd1;    // 0x0001
        exp_e[1] = 16'd4;    // 0x2003: 1 + 3
        exp_e[2] = 16'd18;   // 0x4010: 2 + 16
        exp_e[3] = 16'd259;  // 0xE100: 3 + 256, bit 15 ignored
        skip_id[0] = 2'd3;
        skip_id[1] = 2'd0;
        skip_id[2] = 2'd3;

        // Reset state, with requests present.
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data",  32'(rsp_data),  32'h0);
        chk("rst_rsp_id",    32'(rsp_id),    32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        rst       = 1'b0;
        req_valid = 4'b0000;
        tick();

        // All requesters valid: grants 0,1,2,3,0 and responses two cycles later.
        set_lanes(16'h0001, 16'h2003, 16'h4010, 16'hE100);
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 5) chk($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("rr_vld_%0d", k),  32'(rsp_valid), 32'h1);
                chk($sformatf("rr_id_%0d", k),   32'(rsp_id),    32'((k - 2) % 4));
                chk($sformatf("rr_data_%0d", k), 32'(rsp_data),  32'(exp_e[(k - 2) % 4]));
            end
            tick();
        end
        chk("rr_drained", 32'(busy), 32'h0);

        // Skip idle requesters: pointer at 1, only 0 and 3 valid.
        chk("skip_ptr", 32'(dut.rr_ptr), 32'h1);
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 3) ? 4'b1001 : 4'b0000;
            #1;
            if (k < 3) chk($sformatf("skip_grant_%0d", k), 32'(req_ready), 32'(4'b0001 << skip_id[k]));
            if (k >= 2) chk($sformatf("skip_id_%0d", k), 32'(rsp_id), 32'(skip_id[k - 2]));
            tick();
        end
        tick();

        // Single request from requester 1, c=0x6005 -> e=8.
        set_lanes(16'h0000, 16'h6005, 16'h0000, 16'h0000);
        req_valid = 4'b0010;
        #1;
        chk("single_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        chk("single_lat1_vld", 32'(rsp_valid), 32'h0);
        chk("single_lat1_busy", 32'(busy), 32'h1);
        tick();
        chk("single_vld",  32'(rsp_valid), 32'h1);
        chk("single_data", 32'(rsp_data),  32'd8);
        chk("single_id",   32'(rsp_id),    32'd1);
        tick();
        chk("single_done", 32'(busy), 32'h0);

        // Max value: c=0xFFFF on requester 2 -> 8194.
        set_lanes(16'h0000, 16'h0000, 16'hFFFF, 16'h0000);
        req_valid = 4'b0100;
        #1;
        chk("max_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("max_data", 32'(rsp_data), 32'd8194);
        chk("max_id",   32'(rsp_id),   32'd2);
        tick();

        // Backpressure: pointer at 3, fill with 3 then 0, stall five cycles.
        set_lanes(16'h0001, 16'h2003, 16'h4010, 16'hE100);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant_a", 32'(req_ready), 32'h8);
        tick();
        chk("bp_grant_b", 32'(req_ready), 32'h1);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_ready_%0d", k), 32'(req_ready), 32'h0);
            chk($sformatf("bp_vld_%0d", k),   32'(rsp_valid), 32'h1);
            chk($sformatf("bp_data_%0d", k),  32'(rsp_data),  32'd259);
            chk($sformatf("bp_id_%0d", k),    32'(rsp_id),    32'd3);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'h2);
        chk("bp_release_id",    32'(rsp_id),    32'd3);
        tick();
        req_valid = 4'b0000;
        chk("bp_out2_id",   32'(rsp_id),   32'd0);
        chk("bp_out2_data", 32'(rsp_data), 32'd1);
        tick();
        chk("bp_out3_id",   32'(rsp_id),   32'd1);
        chk("bp_out3_data", 32'(rsp_data), 32'd4);
        tick();
        chk("bp_empty_vld",  32'(rsp_valid), 32'h0);
        chk("bp_empty_busy", 32'(busy),      32'h0);

        // Reset mid-flight: accept 0x7FFF on requester 2, reset two cycles later.
        set_lanes(16'h0000, 16'h0000, 16'h7FFF, 16'h0000);
        req_valid = 4'b0100;
        #1;
        chk("mid_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("mid_pre_vld", 32'(rsp_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid),  32'h0);
        chk("mid_rsp_data",  32'(rsp_data),   32'h0);
        chk("mid_rr_ptr",    32'(dut.rr_ptr), 32'h0);
        chk("mid_busy",      32'(busy),       32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mid_after_%0d", k), 32'(rsp_valid), 32'h0);
        end

`ifdef SEEK_E_ARB_STATS_EN
        // 10 accepts with no backpressure, then 4 stall cycles.
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rsp_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("stat_cnt",   stat_cnt,   32'd10);
        chk("stat_stall", stat_stall, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seek_e_arb.md
Name: seek_e_arb

Overview:
- Shares one `seek_e`-style reduction stage (e = c[14:13] + c[12:0]) between NREQ requesters.
- Round-robin arbitration over valid/ready request ports.
- Two-stage registered pipeline with per-response requester tag and downstream backpressure.
- Sits between the per-lane producers of raw products c and the consumer of reduced values e.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, `Datawidth (16), data width of c and e.
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  NREQ*DW  packed c values; requester i occupies [i*DW +: DW].
- req_ready  output  NREQ  one-hot grant; combinational from req_valid, rr_ptr and pipeline state.
- rsp_valid  output  1  reduced result valid.
- rsp_data  output  DW  e value.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_ready  input  1  downstream accepts the result.
- busy  output  1  high when any pipeline stage holds data.

Behaviour:
- Reset (async, rst=1) clears:
  - s1_vld, s2_vld, rsp_valid and busy to 0;
  - rsp_data and rsp_id to 0;
  - rr_ptr to 0.
  - Any in-flight data is discarded.
  - req_ready=0 while rst=1.
- Handshakes:
  - Request transfer on requester i when req_valid[i] && req_ready[i].
  - Response transfer when rsp_valid && rsp_ready.
- Stage advance:
  - adv2 = !s2_vld || rsp_ready.
  - adv1 = !s1_vld || adv2.
- Arbitration:
  - When adv1=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward with wrap to 0.
  - Otherwise req_ready is all-zero.
  - At most one bit of req_ready is set.
  - Idle requesters are skipped.
- Pointer update: on a transfer from i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
- Stage 1:
  - On adv1, s1_vld <= transfer, and the granted c and tag are captured.
  - If adv1=0, stage 1 holds.
- Stage 2:
  - On adv2, s2_vld <= s1_vld and e <= {zeros, c[14:13]} + {zeros, c[12:0]}.
  - e is zero-extended to DW, maximum 8194.
  - c[DW-1:15] is ignored.
  - The tag moves with the data.
- Outputs:
  - rsp_valid = s2_vld.
  - rsp_data and rsp_id are registered and held stable while rsp_valid && !rsp_ready.
- Latency: accept in cycle N gives rsp_valid at N+2 when there is no backpressure.
- Throughput: 1 result per cycle.
- Full pipeline: with both stages full and rsp_ready=0, req_ready=0. When rsp_ready rises, the same cycle accepts a new request (no bubble).
- busy = s1_vld || s2_vld.
- Request stability: a requester holding req_valid without grant must keep req_data stable. The block does not latch ungranted data.

Optional Feature:
- Macro: SEEK_E_ARB_STATS_EN.
- When defined:
  - adds output stat_cnt [31:0], counting accepted requests (all requesters);
  - wraps at 2^32 and resets to 0 on rst;
  - adds output stat_stall [31:0], counting cycles with s2_vld && !rsp_ready, saturating at all-ones.
- When undefined: neither port nor counter exists and behaviour is otherwise identical.

Decomposition:
- Shared package/header (define.v):
  - `Datawidth;
  - localparams RED_HI=14, RED_MID=13, marking the c[14:13]/c[12:0] split.
- One sub-module: seek_e_arb_rr.
  - Combinational round-robin picker with inputs req_valid, rr_ptr and enable.
  - Outputs are the one-hot grant and the encoded index.
  - rr_ptr remains in the parent.

Test Plan:
- Reset mid-flight: assert rst two cycles after accepting c=16'h7FFF. Then rsp_valid=0, rsp_data=0 and rr_ptr=0 immediately, and no response follows after release.
- Single request: req_valid=4'b0010, c=16'h6005 (c[14:13]=3, c[12:0]=5). Expect rsp_valid 2 cycles later with rsp_data=8, rsp_id=1.
- All requesters valid continuously with rsp_ready=1. Expect grants in order 0,1,2,3,0 on consecutive cycles and rsp_id sequence 0,1,2,3,0, one per cycle.
- Backpressure: fill the pipe, then hold rsp_ready=0 for 5 cycles.
  - req_ready=0 throughout.
  - rsp_data/rsp_id stay stable.
  - On release, no data is lost or duplicated and the order is preserved.
- Skip idle requester: req_valid=4'b1001 with rr_ptr=1. Expect grant 3, then 0, then 3.
- Max value: c=16'hFFFF. Expect rsp_data=16'd8194 (bit 15 ignored).
- With SEEK_E_ARB_STATS_EN: 10 accepts plus 4 stall cycles give stat_cnt=10 and stat_stall=4.
